seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Parametrised, runtime-programmable serial bit-pattern detector.
//  - Watches a qualified serial bit stream and pulses `match` when the last LEN bits equal the programmed pattern.
//  - Selectable overlapping / non-overlapping detection.
//  - Keeps a saturating match counter.
//  - Replaces fixed-pattern hard-coded FSM detectors in protocol front-ends (frame sync, preamble detection).
// PARAMETERS
//  MAX_W    default 8      max pattern length in bits (>=2)
//  DEF_PAT  default 8'h0B  pattern loaded at reset (LSB-aligned, MAX_W bits)
//  DEF_LEN  default 4      pattern length loaded at reset (1..MAX_W)
//  OVERLAP  default 1      1 = overlapping detection, 0 = non-overlapping
//  CNT_W    default 8      width of match counter
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  rst        in   1               asynchronous, active-low reset
//  din_valid  in   1               din is sampled only when high
//  din        in   1               serial data bit
//  cfg_load   in   1               load cfg_pattern/cfg_len this cycle
//  cfg_pattern in  MAX_W           new pattern, LSB-aligned
//  cfg_len    in   $clog2(MAX_W+1) new pattern length
//  cnt_clr    in   1               synchronous clear of match_cnt
//  match      out  1               one-cycle pulse: pattern completed
//  match_cnt  out  CNT_W           saturating count of matches
//  cnt_sat    out  1               high while match_cnt is all-ones
// BEHAVIOUR
//  Reset (rst=0, async)
//  - hist=0, fill=0, pat=DEF_PAT, len=DEF_LEN, match=0, match_cnt=0, cnt_sat=0.
//  Bit order and match rule
//  - pat[len-1] is the earliest bit, pat[0] the latest.
//  - hist shifts left, new bit enters at hist[0].
//  - Match when fill>=len and hist[len-1:0]==pat[len-1:0], evaluated on the new hist.
//  fill
//  - Counts valid bits since reset/load/non-overlap match.
//  - Saturates at MAX_W; it never wraps.
//  Latency
//  - din sampled at edge N produces a registered `match` high in the cycle after edge N.
//  - `match` is high for exactly one cycle; it is 0 on any cycle without din_valid.
//  OVERLAP=1: fill is unchanged after a match.
//  - Example: pattern 101 on 10101 gives two matches.
//  OVERLAP=0: on a match, fill is cleared to 0 and the bits are consumed.
//  - Example: pattern 101 on 10101 gives one match.
//  cfg_load
//  - Latches pat and len, clears hist and fill; match=0 next cycle.
//  - Has priority over din_valid in the same cycle: that bit is discarded.
//  - match_cnt is NOT cleared by cfg_load.
//  - cfg_len=0 is stored as 1; cfg_len>MAX_W is stored as MAX_W.
//  - Bits of cfg_pattern above len are ignored.
//  match_cnt
//  - Increments by 1 on each match, saturates at 2^CNT_W-1; cnt_sat=(match_cnt=={CNT_W{1'b1}}).
//  - cnt_clr sets match_cnt=0; if cnt_clr and a match coincide, cnt_clr wins (result 0), but `match` still pulses.
//  - Counter updates in the same cycle as the `match` register.
//  Reset mid-stream
//  - Async rst=0 immediately forces all outputs to reset values.
//  - Any partial pattern is lost; detection restarts with fill=0.
//  Not a Moore FSM. No combinational path from inputs to outputs.
// TESTING
//  T1 Reset default, pattern 1011, len 4.
//     Stream 1,0,1,1,0,1,1 (all valid) -> match pulses after bits 4 and 7 (overlap); match_cnt=2.
//  T2 OVERLAP=0 build, cfg 101 len 3.
//     Stream 1,0,1,0,1 -> single match after bit 3; match_cnt=1.
//  T3 din_valid gaps.
//     Pattern 1011 with din_valid low between bits (din toggling randomly when invalid) -> one match; no pulse on invalid cycles.
//  T4 cfg_load together with din_valid=1.
//     cfg_load with cfg_pattern=8'hA5, cfg_len=8 -> bit dropped, fill=0.
//     Then feed 10100101 -> match after 8th bit only.
//  T5 Saturation, CNT_W=2.
//     Produce 5 matches -> match_cnt 1,2,3,3,3 and cnt_sat=1 from 3rd.
//     cnt_clr on a match cycle -> match=1, match_cnt=0.
//  T6 Async reset mid-stream.
//     Feed 1,0,1 of 1011, pulse rst low between edges -> outputs 0 immediately.
//     Then 1 alone -> no match; full 1011 -> match.
//  T7 Length clamping.
//     cfg_len=0 with cfg_pattern=1 -> every valid 1 matches.
//     cfg_len=15 (MAX_W=8) -> behaves as len 8.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlapping or
// non-overlapping detection and a saturating match counter.
module seq_detector_prog #(
  parameter int               MAX_W   = 8,
  parameter logic [MAX_W-1:0] DEF_PAT = MAX_W'(8'h0B),
  parameter int               DEF_LEN = 4,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic                         din,
  input  logic                         cfg_load,
  input  logic [MAX_W-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_len,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int               LEN_W = $clog2(MAX_W + 1);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_W);

  // Out-of-range lengths fold into the legal range 1..MAX_W.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    if (l > MAX_L) return MAX_L;
    return l;
  endfunction

  function automatic logic [MAX_W-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_W-1:0] m;
    for (int i = 0; i < MAX_W; i++) begin
      m[i] = (LEN_W'(i) < l);
    end
    return m;
  endfunction

  localparam logic [LEN_W-1:0] RST_LEN = clamp_len(LEN_W'(DEF_LEN));

  logic [MAX_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [MAX_W-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0] len_q,  len_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [MAX_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] new_len;
  logic             hit;

  always_comb begin
    hist_shift = {hist_q[MAX_W-2:0], din};
    fill_inc   = (fill_q == MAX_L) ? fill_q : fill_q + LEN_W'(1);
    new_len    = clamp_len(cfg_len);
    // pat_q is stored pre-masked, so only the history needs masking here.
    hit        = din_valid && (fill_inc >= len_q) &&
                 ((hist_shift & len_mask(len_q)) == pat_q);
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    match_d = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pattern & len_mask(new_len);
      len_d  = new_len;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d  = hist_shift;
      fill_d  = (hit && !OVERLAP) ? '0 : fill_inc;
      match_d = hit;
    end
  end

  // Clear beats increment; the count tracks the match register update.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PAT & len_mask(RST_LEN);
      len_q   <= RST_LEN;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench: three detector builds (default, non-overlapping, 2-bit
// counter) share one stimulus stream; each step checks against hand values.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid, din, cfg_load, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic       m0, m1, m2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic       s0, s1, s2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detector_prog u0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clr(cnt_clr), .match(m0), .match_cnt(c0), .cnt_sat(s0));

  seq_detector_prog #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clr(cnt_clr), .match(m1), .match_cnt(c1), .cnt_sat(s1));

  seq_detector_prog #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cnt_clr(cnt_clr), .match(m2), .match_cnt(c2), .cnt_sat(s2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds bits[n-1] first; e0 applies to the overlapping builds, e1 to u1.
  task automatic feed(input string tag, input logic [15:0] bits, input int n,
                      input logic [15:0] e0, input logic [15:0] e1);
    for (int i = n - 1; i >= 0; i--) begin
      din       = bits[i];
      din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      chk({tag, "_m0"}, m0, e0[i]);
      chk({tag, "_m1"}, m1, e1[i]);
      chk({tag, "_m2"}, m2, e0[i]);
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic v, input logic d);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_load    = 1'b1;
    din_valid   = v;
    din         = d;
    @(posedge clk); #1;
    cfg_load    = 1'b0;
    din_valid   = 1'b0;
    chk("load_m0", m0, 1'b0);
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_c0", c0, 8'd0);
    chk("clr_c2", c2, 2'd0);
  endtask

  initial begin
    rst = 1'b0; din_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
    cnt_clr = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    #12;
    chk("rst_match", m0, 1'b0);
    chk("rst_cnt",   c0, 8'd0);
    chk("rst_sat",   s0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: default 1011, overlap on u0/u2, non-overlap on u1
    feed("t1", 16'b1011011, 7, 16'b0001001, 16'b0001000);
    chk("t1_c0", c0, 8'd2);
    chk("t1_c1", c1, 8'd1);
    chk("t1_c2", c2, 2'd2);
    chk("t1_s2", s2, 1'b0);

    // T2: 101 on 10101
    clr();
    load(8'h05, 4'd3, 1'b0, 1'b0);
    feed("t2", 16'b10101, 5, 16'b00101, 16'b00100);
    chk("t2_c0", c0, 8'd2);
    chk("t2_c1", c1, 8'd1);

    // T4: bit presented with cfg_load is dropped
    load(8'hA5, 4'd8, 1'b1, 1'b1);
    feed("t4a", 16'b0100101, 7, 16'b0, 16'b0);
    load(8'hA5, 4'd8, 1'b0, 1'b0);
    feed("t4b", 16'b10100101, 8, 16'b00000001, 16'b00000001);
    chk("t4_c0", c0, 8'd3);

    // T3: din_valid gaps with junk on din
    load(8'h0B, 4'd4, 1'b0, 1'b0);
    for (int b = 3; b >= 0; b--) begin
      feed("t3", 16'((4'b1011 >> b) & 1), 1, 16'(b == 0), 16'(b == 0));
      for (int g = 0; g < 2; g++) begin
        din = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        chk("t3_gap", m0, 1'b0);
      end
    end
    chk("t3_c0", c0, 8'd4);

    // T6: async reset with a partial pattern pending
    feed("t6a", 16'b101, 3, 16'b0, 16'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_m0", m0, 1'b0);
    chk("t6_c0", c0, 8'd0);
    chk("t6_c2", c2, 2'd0);
    chk("t6_s0", s0, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    feed("t6b", 16'b1, 1, 16'b0, 16'b0);
    feed("t6c", 16'b1011, 4, 16'b0001, 16'b0001);

    // T7a: length 0 clamps to 1, pattern 1
    load(8'h01, 4'd0, 1'b0, 1'b0);
    feed("t7a", 16'b1011, 4, 16'b1011, 16'b1011);

    // T5: 2-bit counter saturation
    clr();
    for (int k = 1; k <= 5; k++) begin
      feed("t5", 16'b1, 1, 16'b1, 16'b1);
      chk("t5_c2", c2, (k < 3) ? 32'(k) : 32'd3);
      chk("t5_s2", s2, (k >= 3) ? 32'd1 : 32'd0);
    end
    chk("t5_c0", c0, 8'd5);
    cnt_clr = 1'b1;
    feed("t5clr", 16'b1, 1, 16'b1, 16'b1);
    cnt_clr = 1'b0;
    chk("t5clr_c2", c2, 2'd0);
    chk("t5clr_c0", c0, 8'd0);
    chk("t5clr_s2", s2, 1'b0);

    // T7b: length 15 clamps to 8
    load(8'hA5, 4'd15, 1'b0, 1'b0);
    feed("t7b", 16'b10100101, 8, 16'b00000001, 16'b00000001);
    chk("t7b_c0", c0, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
